// File: rtl/shift_stim_pkg.sv
// Shared types for the shift stimulus generator: shift-mode encoding,
// FSM state enumeration and a parity helper.
package shift_stim_pkg;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASL = 2'b10,
        SHIFT_ASR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic parity_of(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-step combinational shifter: moves the word one bit in the
// direction selected by mode.
module shift_step
    import shift_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  shift_mode_e        mode,
    input  logic [WIDTH-1:0]   in,
    output logic [WIDTH-1:0]   out
);

    always_comb begin
        out = '0;
        unique case (mode)
            SHIFT_LSL,
            SHIFT_ASL: out = {in[WIDTH-2:0], 1'b0};
            SHIFT_LSR: out = {1'b0, in[WIDTH-1:1]};
            SHIFT_ASR: out = {in[WIDTH-1], in[WIDTH-1:1]};
            default:   out = '0;
        endcase
    end

endmodule

// File: rtl/shift_stim_gen.sv
// Emits count words starting at seed, each the previous word shifted by one
// bit, over a valid/ready stream with a one-cycle done pulse at the end.
module shift_stim_gen
    import shift_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    state_e            state;
    state_e            state_nxt;
    shift_mode_e       mode_q;
    logic [CNT_W-1:0]  remain;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  data_shifted;
    logic              par_q;
    logic              load;
    logic              advance;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode (mode_q),
        .in   (data_q),
        .out  (data_shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over a beat offered in the same cycle.
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (out_ready) begin
                    advance = 1'b1;
                    if (remain == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            par_q  <= 1'b0;
            mode_q <= SHIFT_LSL;
            remain <= '0;
        end else if (load) begin
            data_q <= seed;
            par_q  <= parity_of(64'(seed));
            mode_q <= shift_mode_e'(mode);
            remain <= count;
        end else if (advance) begin
            data_q <= data_shifted;
            par_q  <= parity_of(64'(data_shifted));
            remain <= remain - CNT_W'(1);
        end
    end

    assign out_data = data_q;
    assign out_par  = par_q;

endmodule

// File: tb/tb_shift_stim_gen.sv
// Randomized scoreboard bench for shift_stim_gen: the driver queues expected
// words from an arithmetic model; a monitor checks every presented word.
module tb_shift_stim_gen;

    localparam int unsigned W  = 9;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  seed;
    logic [1:0]    mode;
    logic [CW-1:0] count;
    logic [W-1:0]  out_data;
    logic          out_par;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         par;
    } exp_t;
    exp_t sb[$];

    shift_stim_gen #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .seed      (seed),
        .mode      (mode),
        .count     (count),
        .out_data  (out_data),
        .out_par   (out_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one-bit shifts expressed as integer multiply/divide.
    function automatic int unsigned model_next(input int unsigned w, input int unsigned m);
        int unsigned v;
        case (m)
            0, 2:    v = (w * 2) % (1 << W);
            1:       v = w / 2;
            default: v = w / 2 + ((w >= (1 << (W - 1))) ? (1 << (W - 1)) : 0);
        endcase
        return v;
    endfunction

    function automatic logic model_par(input int unsigned w);
        return logic'($countones(w) % 2);
    endfunction

    // Monitor: every presented word must be the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("beat_data", 32'(out_data), 32'(sb[0].data));
                check("beat_par", 32'(out_par), 32'(sb[0].par));
                if (out_ready && !abort) void'(sb.pop_front());
            end
        end
    end

    // Issues one sequence from the current time (which must be between edges).
    // stop_after != 0 returns at the negedge where that many beats were offered.
    task automatic run_seq(input int unsigned s, input int unsigned m, input int unsigned cnt,
                           input int unsigned pct, input int unsigned stall_at,
                           input int unsigned stop_after);
        int unsigned w = s;
        int unsigned beats = 0;
        int unsigned stall_left = 0;
        bit stalled = 0;
        bit finished = 0;
        for (int unsigned i = 0; i < cnt; i++) begin
            sb.push_back('{data: W'(w), par: model_par(w)});
            w = model_next(w, m);
        end
        start = 1'b1; seed = W'(s); mode = 2'(m); count = CW'(cnt); out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (cnt == 0) begin
            @(negedge clk);
            check("zero_done", 32'(done), 32'd1);
            check("zero_valid", 32'(out_valid), 32'd0);
            check("zero_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("zero_done_once", 32'(done), 32'd0);
            check("zero_valid_after", 32'(out_valid), 32'd0);
            return;
        end
        for (int unsigned cyc = 0; cyc < cnt * 40 + 20; cyc++) begin
            if (stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else if (stall_at != 0 && beats == stall_at - 1 && !stalled) begin
                out_ready = 1'b0; stalled = 1; stall_left = 1;
            end else begin
                out_ready = ($urandom_range(0, 99) < pct);
            end
            // start is junk during RUN and must be ignored
            start = 1'($urandom_range(0, 1));
            seed  = W'($urandom);
            count = CW'($urandom);
            @(negedge clk);
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            if (out_valid && out_ready) beats++;
            if (stop_after != 0 && beats == stop_after) return;
            if (beats == cnt) begin finished = 1; break; end
            @(posedge clk); #1;
        end
        if (!finished) begin
            n_cmp++; n_err++;
            $display("FAIL seq_timeout: got %0d beats expected %0d", beats, cnt);
        end
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; mode = '0; count = '0;
        out_ready = 1'b0;
        #2;
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_par", 32'(out_par), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Start accepted on the very first edge after reset release.
        run_seq(9'h001, 0, 3, 100, 0, 0);
        @(posedge clk); #1;
        run_seq(9'h100, 3, 3, 100, 0, 0);
        @(posedge clk); #1;
        run_seq(9'h0F0, 1, 4, 100, 2, 0);
        @(posedge clk); #1;
        run_seq(9'h055, 2, 0, 100, 0, 0);
        @(posedge clk); #1;
        run_seq(9'h1FF, 3, 12, 100, 0, 0);
        @(posedge clk); #1;
        run_seq(9'h101, 0, 11, 70, 0, 0);

        // Reset mid-run after two beats.
        @(posedge clk); #1;
        run_seq(9'h0A5, 1, 5, 100, 0, 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_par", 32'(out_par), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        sb.delete();
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        run_seq(9'h133, 0, 4, 100, 0, 0);

        // Abort together with out_ready.
        @(posedge clk); #1;
        run_seq(9'h081, 1, 5, 100, 0, 2);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_idle", 32'(out_valid), 32'd0);
        sb.delete();

        for (int unsigned i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            run_seq($urandom_range(0, 511), $urandom_range(0, 3), $urandom_range(0, 12),
                    $urandom_range(30, 100), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
